// File: rtl/sn_pkg.sv
// sn_pkg: definitions shared by the stochastic-number datapath blocks
// (binary-to-stream generator and stream-to-binary counter).
//   SN_LEN_DEF : default stream length in cycles
//   BN_W_DEF   : default binary result width
//   CNT_W_DEF  : width of a count that can hold 0..SN_LEN_DEF
//   sn2bn_state_t : converter FSM states
package sn_pkg;
  localparam int SN_LEN_DEF = 16;
  localparam int BN_W_DEF   = 4;
  localparam int CNT_W_DEF  = $clog2(SN_LEN_DEF + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} sn2bn_state_t;
  typedef logic [CNT_W_DEF-1:0] sn_cnt_t;
endpackage

// File: rtl/sn_lane_counter.sv
// sn_lane_counter: per-lane ones counter for one stochastic bit stream.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : first slot of a stream, count restarts at i_bit
//   i_add          : later slot, count accumulates i_bit
//   i_bit          : stream bit for this lane
//   o_val          : saturated value of the count including this cycle's bit
//   o_sat          : that count exceeded the o_val range
// o_val/o_sat are combinational from the next-count so the parent can
// capture the result in the same cycle the final bit arrives.
module sn_lane_counter #(
  parameter int SN_LEN = 16,
  parameter int BN_W   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_add,
  input  logic            i_bit,
  output logic [BN_W-1:0] o_val,
  output logic            o_sat
);
  localparam int CW = $clog2(SN_LEN + 1);
  localparam logic [31:0] MAXV = 32'((1 << BN_W) - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load)     w_cnt_nxt = CW'(i_bit);
    else if (i_add) w_cnt_nxt = r_cnt + CW'(i_bit);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end

  always_comb begin
    o_sat = (32'(w_cnt_nxt) > MAXV);
    o_val = o_sat ? '1 : BN_W'(w_cnt_nxt);
  end
endmodule

// File: rtl/sn2bn_counter.sv
// sn2bn_counter: stochastic-to-binary converter. Counts ones in LANES
// parallel unipolar streams of up to SN_LEN bits and presents one saturated
// BN_W-bit value per lane through a valid/ready result register.
//   i_clk_sn2bn, i_rst_n_sn2bn : clock, async active-low reset
//   i_isgen   : stream qualifier, lane bits valid while high
//   i_sn_bit  : per-lane stream bits
//   i_ready   : consumer accepts the held result
//   o_valid   : result held until accepted
//   o_x_bn    : per-lane counted value
//   o_trunc   : result came from a stream shorter than SN_LEN
//   o_sat     : per-lane saturation flag
//   o_ovf     : sticky, a finished stream was dropped (result reg full)
module sn2bn_counter
  import sn_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int SN_LEN = SN_LEN_DEF,
  parameter int BN_W   = BN_W_DEF
) (
  input  logic             i_clk_sn2bn,
  input  logic             i_rst_n_sn2bn,
  input  logic             i_isgen,
  input  logic             i_sn_bit [LANES],
  input  logic             i_ready,
  output logic             o_valid,
  output logic [BN_W-1:0]  o_x_bn [LANES],
  output logic             o_trunc,
  output logic [LANES-1:0] o_sat,
  output logic             o_ovf
);
  localparam int   CW       = $clog2(SN_LEN + 1);
  localparam logic ONE_SLOT = (SN_LEN == 1);

  sn2bn_state_t     r_state;
  logic [CW-1:0]    r_slot;
  logic             r_valid;
  logic [BN_W-1:0]  r_x [LANES];
  logic [LANES-1:0] r_sat;
  logic             r_trunc;
  logic             r_ovf;

  logic             w_start;
  logic             w_add;
  logic             w_last;
  logic             w_done_full;
  logic             w_done_trunc;
  logic             w_done;
  logic [BN_W-1:0]  w_val [LANES];
  logic [LANES-1:0] w_sat;

  assign w_start      = (r_state == S_IDLE) && i_isgen;
  assign w_add        = (r_state == S_ACC) && i_isgen;
  // slot counts bits already taken; the bit arriving now is slot r_slot+1
  assign w_last       = (r_slot == CW'(SN_LEN - 1));
  assign w_done_full  = (w_start && ONE_SLOT) || (w_add && w_last);
  // early drop of i_isgen: lane counts are unchanged, so the comb
  // next-count equals the held count and the same capture path works
  assign w_done_trunc = (r_state == S_ACC) && !i_isgen;
  assign w_done       = w_done_full || w_done_trunc;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sn_lane_counter #(
      .SN_LEN (SN_LEN),
      .BN_W   (BN_W)
    ) u_cnt (
      .i_clk   (i_clk_sn2bn),
      .i_rst_n (i_rst_n_sn2bn),
      .i_load  (w_start),
      .i_add   (w_add),
      .i_bit   (i_sn_bit[g]),
      .o_val   (w_val[g]),
      .o_sat   (w_sat[g])
    );
  end

  // Stream FSM. HOLD absorbs an over-long i_isgen so a new stream can only
  // start after the qualifier has been low for a cycle.
  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_isgen) begin
            r_slot  <= CW'(1);
            r_state <= ONE_SLOT ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (!i_isgen) begin
            r_state <= S_IDLE;
          end else begin
            r_slot <= r_slot + CW'(1);
            if (w_last) r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!i_isgen) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result register. An accept in the completion cycle frees the slot, so
  // the new result loads and valid stays high without overflow.
  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      r_valid <= 1'b0;
      r_sat   <= '0;
      r_trunc <= 1'b0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < LANES; k++) r_x[k] <= '0;
    end else begin
      if (w_done) begin
        if (!r_valid || i_ready) begin
          r_valid <= 1'b1;
          r_sat   <= w_sat;
          r_trunc <= w_done_trunc;
          for (int k = 0; k < LANES; k++) r_x[k] <= w_val[k];
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_x_bn  = r_x;
  assign o_trunc = r_trunc;
  assign o_sat   = r_sat;
  assign o_ovf   = r_ovf;
endmodule
